tdc_spi_init: RTL and testbench
===============================

# tdc_spi_init

Per-channel TDC register initialiser, directly downstream of the TDC power/enable controller. On each soft-reset request it runs a fixed SPI write sequence into one TDC7200 (CONFIG2, INT_MASK, CONFIG1), optionally reads CONFIG2 back for verification, and reports completion. The board uses one instance per channel (f1..f6).

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range ≥2.
- CFG2_VAL, 8'h40: value written to CONFIG2 (address 0x01).
- INT_MASK_VAL, 8'h07: value written to INT_MASK (address 0x03).
- CFG1_VAL, 8'h02: value written to CONFIG1 (address 0x00).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tdc_enable  in  1  TDC enable level; must be high for a sequence to start or continue
- soft_reset  in  1  request; a rising edge (0 in previous cycle, 1 in current cycle) triggers a sequence
- pause  in  1  while high, new triggers are ignored; does not affect a running sequence
- spi_miso  in  1  TDC serial data out
- spi_csb  out  1  chip select, active-low
- spi_sclk  out  1  serial clock, mode 0 (idle low)
- spi_mosi  out  1  serial data in to TDC, MSB first
- busy  out  1  sequence in progress
- init_done  out  1  sticky: last sequence completed
- init_error  out  1  sticky: readback mismatch in last sequence

## Operation
- Reset values: spi_csb=1, spi_sclk=0, spi_mosi=0, busy=0, init_done=0, init_error=0, edge-detect register=0.
- Trigger accepted only in IDLE with tdc_enable=1 and pause=0; otherwise ignored, not queued. Edges that arrive while busy are ignored.
- On acceptance, init_done and init_error are cleared, and busy is set.
- Frame format: 16 bits. Command byte = {auto_inc=0, rw, addr[5:0]}, with rw=1 for write and rw=0 for read. This is followed by the data byte.
- Transaction list, in order:
  - write 0x01 ← CFG2_VAL
  - write 0x03 ← INT_MASK_VAL
  - write 0x00 ← CFG1_VAL
  - read 0x01 (readback build only)
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → GAP → (next transaction: CS_SETUP | last: DONE) → IDLE.
  - DONE lasts one cycle. It sets init_done, and it sets init_error when the readback byte ≠ CFG2_VAL.
- MOSI is updated on SCLK falling edges; the first bit is presented at CS_SETUP entry. MISO is sampled on SCLK rising edges. The readback byte is the last 8 sampled bits.
- Abort: if tdc_enable goes low in any non-IDLE state, the next cycle drives csb=1, sclk=0, mosi=0, busy=0, and the FSM returns to IDLE. init_done and init_error stay 0.
- A rst assertion mid-sequence forces all reset values at the next clk edge. No partial frame is completed.

## Timing
- Trigger edge sampled at cycle t0; spi_csb falls and busy rises at t0+1.
- Per transaction:
  - CS_SETUP: CLK_DIV cycles
  - SHIFT: 16 × 2·CLK_DIV cycles
  - CS_HOLD: CLK_DIV cycles, with SCLK low
  - GAP: CLK_DIV cycles, with csb high
  - Total: 35·CLK_DIV cycles.
- init_done rises at t0+1+N·35·CLK_DIV, with N=4 (readback) or N=3. busy falls in the same cycle.
- With the default CLK_DIV=4: 561 cycles with readback, 421 without.
- SCLK high and low phases are exactly CLK_DIV cycles each. spi_csb never toggles while SCLK is high.

## Configuration
- TDC_READBACK_EN defined: the fourth (read) transaction is performed and init_error is meaningful.
- TDC_READBACK_EN undefined: three write transactions only. init_error is tied to 0, and spi_miso is unused.

## Structure
- Shared package tdc_pkg holds:
  - TDC7200 register addresses (CONFIG1=0x00, CONFIG2=0x01, INT_STATUS=0x02, INT_MASK=0x03)
  - the rw/auto_inc bit positions
  - the FSM state encoding
  - a command-byte construction function.
- One sub-module, spi_shift16: a single mode-0 16-bit transfer engine with start/done handshake, the CLK_DIV parameter, and a 16-bit tx in / 8-bit rx out. The top level owns sequencing, trigger qualification, abort and the status flags.

## Test plan
- Default params with TDC_READBACK_EN; tdc_enable=1, pulse soft_reset for 1 cycle, MISO model returns 0x40 → MOSI frames 0x4140, 0x4307, 0x4002, 0x0100. init_done=1 at t0+561, init_error=0.
- Same stimulus, but the MISO model returns 0x41 on readback → init_done=1 and init_error=1 at t0+561.
- Trigger with pause=1, or with tdc_enable=0 → spi_csb stays 1, busy stays 0, no SCLK edges.
- Drop tdc_enable during the second frame → the next cycle has csb=1, sclk=0, busy=0. init_done stays 0, and a later trigger restarts from the 0x4140 frame.
- Second soft_reset edge while busy → ignored: exactly 4 frames and a single init_done rise. Assert rst mid-frame → all outputs at reset values the next cycle.
- TDC_READBACK_EN undefined, CLK_DIV=2 → 3 frames, init_done at t0+211, init_error constantly 0.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: TDC7200 register map, SPI command-byte layout and initialiser FSM states.
package tdc_pkg;

  localparam logic [5:0] ADDR_CONFIG1    = 6'h00;
  localparam logic [5:0] ADDR_CONFIG2    = 6'h01;
  localparam logic [5:0] ADDR_INT_STATUS = 6'h02;
  localparam logic [5:0] ADDR_INT_MASK   = 6'h03;

  localparam int   CMD_AUTO_INC_BIT = 7;
  localparam int   CMD_RW_BIT       = 6;
  localparam logic CMD_WRITE        = 1'b1;
  localparam logic CMD_READ         = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP,
    ST_DONE
  } tdc_state_e;

  // Auto-increment is never used: every register is addressed by its own frame.
  function automatic logic [7:0] cmd_byte(input logic rw, input logic [5:0] addr);
    logic [7:0] c;
    c                   = {2'b00, addr};
    c[CMD_RW_BIT]       = rw;
    c[CMD_AUTO_INC_BIT] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/tdc_spi_init_if.sv
// tdc_spi_init_if: control, status and SPI pins of one TDC initialiser channel.
interface tdc_spi_init_if;

  logic tdc_enable;
  logic soft_reset;
  logic pause;
  logic spi_miso;
  logic spi_csb;
  logic spi_sclk;
  logic spi_mosi;
  logic busy;
  logic init_done;
  logic init_error;

  modport master (
    output tdc_enable, soft_reset, pause, spi_miso,
    input  spi_csb, spi_sclk, spi_mosi, busy, init_done, init_error
  );

  modport slave (
    input  tdc_enable, soft_reset, pause, spi_miso,
    output spi_csb, spi_sclk, spi_mosi, busy, init_done, init_error
  );

endinterface

// File: rtl/tdc_spi_init_spi_shift16.sv
// spi_shift16: one mode-0, MSB-first 16-bit SPI transfer; SCLK phases are CLK_DIV clk cycles each.
module spi_shift16
#(
  parameter int CLK_DIV = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic        i_start,
  input  logic [15:0] i_tx,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_done,
  output logic [7:0]  o_rx
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_phase;
  logic [4:0]    r_half;
  logic          r_run;
  logic          r_sclk;
  logic [15:0]   r_tx;
  logic [7:0]    r_rx;
  logic          w_phase_end;

  assign w_phase_end = (r_phase == CW'(CLK_DIV - 1));
  assign o_done      = r_run && w_phase_end && !r_sclk && (r_half == 5'd31);
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_tx[15];
  assign o_rx        = r_rx;

  // Even half-phases are SCLK high, odd ones low; the 32nd (low) half-phase ends the transfer.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_phase <= '0;
      r_half  <= '0;
      r_run   <= 1'b0;
      r_sclk  <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_tx;
      end
      if (i_start) begin
        r_run   <= 1'b1;
        r_sclk  <= 1'b1;
        r_phase <= '0;
        r_half  <= '0;
        r_rx    <= {r_rx[6:0], i_miso};
      end else if (r_run) begin
        if (!w_phase_end) begin
          r_phase <= r_phase + CW'(1);
        end else begin
          r_phase <= '0;
          if (r_sclk) begin
            r_sclk <= 1'b0;
            r_tx   <= {r_tx[14:0], 1'b0};
            r_half <= r_half + 5'd1;
          end else if (r_half == 5'd31) begin
            r_run <= 1'b0;
          end else begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[6:0], i_miso};
            r_half <= r_half + 5'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tdc_spi_init.sv
// tdc_spi_init: writes CONFIG2, INT_MASK, CONFIG1 into a TDC7200 on each accepted soft_reset edge.
// Define TDC_READBACK_EN to add a CONFIG2 readback frame that drives init_error.
module tdc_spi_init
  import tdc_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter logic [7:0] CFG2_VAL     = 8'h40,
  parameter logic [7:0] INT_MASK_VAL = 8'h07,
  parameter logic [7:0] CFG1_VAL     = 8'h02
)
(
  input logic           clk,
  input logic           rst,
  tdc_spi_init_if.slave bus
);

  localparam int CW = $clog2(CLK_DIV);

`ifdef TDC_READBACK_EN
  localparam logic [1:0] LAST_TXN = 2'd3;
`else
  localparam logic [1:0] LAST_TXN = 2'd2;
`endif

  tdc_state_e    r_state;
  tdc_state_e    w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_txn;
  logic          r_soft_prev;
  logic          r_init_done;

  logic          w_trigger;
  logic          w_phase_end;
  logic          w_load;
  logic          w_start;
  logic          w_abort;
  logic          w_accept;
  logic          w_finish;
  logic          w_txn_inc;
  logic [1:0]    w_load_idx;
  logic [15:0]   w_tx;
  logic          w_miso;
  logic          w_sclk;
  logic          w_mosi;
  logic          w_eng_done;
  logic [7:0]    w_rx;

  function automatic logic [15:0] frame_for(input logic [1:0] idx);
    logic [15:0] f;
    case (idx)
      2'd0:    f = {cmd_byte(CMD_WRITE, ADDR_CONFIG2), CFG2_VAL};
      2'd1:    f = {cmd_byte(CMD_WRITE, ADDR_INT_MASK), INT_MASK_VAL};
      2'd2:    f = {cmd_byte(CMD_WRITE, ADDR_CONFIG1), CFG1_VAL};
      default: f = {cmd_byte(CMD_READ, ADDR_CONFIG2), 8'h00};
    endcase
    return f;
  endfunction

  assign w_trigger   = bus.soft_reset && !r_soft_prev && bus.tdc_enable && !bus.pause;
  assign w_phase_end = (r_cnt == CW'(CLK_DIV - 1));
  assign w_load_idx  = w_accept ? 2'd0 : (r_txn + 2'd1);
  assign w_tx        = frame_for(w_load_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Losing tdc_enable overrides every transition and drops the sequence back to IDLE.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_start   = 1'b0;
    w_abort   = 1'b0;
    w_accept  = 1'b0;
    w_finish  = 1'b0;
    w_txn_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_next   = ST_CS_SETUP;
          w_load   = 1'b1;
          w_accept = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (w_phase_end) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_eng_done) begin
          w_next = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (w_phase_end) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_phase_end) begin
          if (r_txn == LAST_TXN) begin
            w_next   = ST_DONE;
            w_finish = 1'b1;
          end else begin
            w_next    = ST_CS_SETUP;
            w_load    = 1'b1;
            w_txn_inc = 1'b1;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !bus.tdc_enable) begin
      w_next    = ST_IDLE;
      w_load    = 1'b0;
      w_start   = 1'b0;
      w_accept  = 1'b0;
      w_finish  = 1'b0;
      w_txn_inc = 1'b0;
      w_abort   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_soft_prev <= 1'b0;
      r_init_done <= 1'b0;
      r_txn       <= '0;
    end else begin
      r_soft_prev <= bus.soft_reset;
      if (w_accept) begin
        r_init_done <= 1'b0;
        r_txn       <= '0;
      end else if (w_txn_inc) begin
        r_txn <= r_txn + 2'd1;
      end
      if (w_finish) begin
        r_init_done <= 1'b1;
      end
    end
  end

`ifdef TDC_READBACK_EN
  logic r_init_error;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_init_error <= 1'b0;
    end else if (w_finish) begin
      r_init_error <= (w_rx != CFG2_VAL);
    end
  end

  assign bus.init_error = r_init_error;
  assign w_miso         = bus.spi_miso;
`else
  logic w_unused;

  assign w_unused       = ^{w_rx, bus.spi_miso};
  assign bus.init_error = 1'b0;
  assign w_miso         = 1'b0;
`endif

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_abort),
    .i_load  (w_load),
    .i_start (w_start),
    .i_tx    (w_tx),
    .i_miso  (w_miso),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi),
    .o_done  (w_eng_done),
    .o_rx    (w_rx)
  );

  assign bus.spi_csb   = !((r_state == ST_CS_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_CS_HOLD));
  assign bus.spi_sclk  = w_sclk;
  assign bus.spi_mosi  = w_mosi;
  assign bus.busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_tdc_spi_init.sv
// tb_tdc_spi_init: vector table plus hand-written abort/retrigger/reset sequences, frames checked by a scoreboard.
module tb_tdc_spi_init;

`ifdef TDC_READBACK_EN
  localparam int CLK_DIV = 4;
  localparam int NTXN    = 4;
  localparam bit RB      = 1'b1;
`else
  localparam int CLK_DIV = 2;
  localparam int NTXN    = 3;
  localparam bit RB      = 1'b0;
`endif
  localparam int EXP_DONE = 1 + NTXN * 35 * CLK_DIV;

  typedef struct {
    logic       en;
    logic       pz;
    logic [7:0] rb;
    bit         run;
    logic       expDone;
    logic       expErr;
  } vec_t;

  logic clk;
  logic rst;
  tdc_spi_init_if bus();

  int          assertCount = 0;
  int          failCount   = 0;
  logic [15:0] expQ[$];
  logic [7:0]  rbByte      = 8'h40;
  int          partialFrames = 0;
  int          framesSeen  = 0;
  int          sclkEdges   = 0;
  int          doneRises   = 0;

  tdc_spi_init #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Frame scoreboard, SCLK/CSB timing checks and the MISO model of the TDC.
  logic        prevCsb  = 1'b1;
  logic        prevSclk = 1'b0;
  logic        prevDone = 1'b0;
  logic [15:0] shiftReg = '0;
  int          bitCnt   = 0;
  int          fallCnt  = 0;
  int          hiLen    = 0;

  always @(negedge clk) begin
    logic [15:0] expFrame;
    int          j;
    if (bus.spi_csb) bus.spi_miso = 1'b0;
    if (bus.spi_sclk !== prevSclk) sclkEdges++;
    if (bus.init_done === 1'b1 && prevDone === 1'b0) doneRises++;
    if (bus.spi_csb !== prevCsb) begin
      assertCount++;
      if (bus.spi_sclk !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL csb_sclk_high: csb changed with sclk %0b required 0", bus.spi_sclk);
      end
    end
    if (prevCsb && !bus.spi_csb) begin
      bitCnt   = 0;
      fallCnt  = 0;
      shiftReg = '0;
    end
    if (!bus.spi_csb && !prevSclk && bus.spi_sclk) begin
      shiftReg = {shiftReg[14:0], bus.spi_mosi};
      bitCnt++;
      hiLen = 0;
    end
    if (!bus.spi_csb && prevSclk && !bus.spi_sclk) begin
      checkOutput("sclk_high_len", hiLen, CLK_DIV);
      fallCnt++;
      j = fallCnt - 8;
      bus.spi_miso = (j >= 0 && j < 8) ? rbByte[7 - j] : 1'b0;
    end
    if (bus.spi_sclk) hiLen++;
    if (!prevCsb && bus.spi_csb) begin
      if (bitCnt == 16) begin
        framesSeen++;
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL frame_unexpected: got %04h expected none", shiftReg);
        end else begin
          expFrame = expQ.pop_front();
          checkOutput("mosi_frame", {16'h0, shiftReg}, {16'h0, expFrame});
        end
      end else begin
        partialFrames++;
      end
    end
    prevCsb  = bus.spi_csb;
    prevSclk = bus.spi_sclk;
    prevDone = bus.init_done;
  end

  task automatic pushFrames();
    expQ.push_back(16'h4140);
    expQ.push_back(16'h4307);
    expQ.push_back(16'h4002);
    if (RB) expQ.push_back(16'h0100);
  endtask

  // Returns on the first negedge after the trigger-sampling edge (cycle t0+1).
  task automatic pulseTrigger();
    @(negedge clk);
    bus.soft_reset = 1'b1;
    @(negedge clk);
    bus.soft_reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic en, input logic pz, input logic [7:0] rb,
                               input bit run, input bit retrigger);
    int   k;
    int   doneAt;
    int   edges0;
    int   quietBad;
    logic prevBusy;
    rbByte         = rb;
    bus.tdc_enable = en;
    bus.pause      = pz;
    if (run) pushFrames();
    edges0 = sclkEdges;
    pulseTrigger();
    checkOutput("start_busy", bus.busy, run);
    checkOutput("start_csb", bus.spi_csb, !run);
    if (run) begin
      k        = 1;
      doneAt   = -1;
      prevBusy = bus.busy;
      while (k < EXP_DONE + 40 && !(doneAt >= 0 && k >= doneAt + 20)) begin
        @(negedge clk);
        k++;
        if (retrigger && k == 100) bus.soft_reset = 1'b1;
        if (retrigger && k == 101) bus.soft_reset = 1'b0;
        if (doneAt < 0 && bus.init_done === 1'b1) begin
          doneAt = k;
          checkOutput("done_busy_low", bus.busy, 1'b0);
          checkOutput("busy_before_done", prevBusy, 1'b1);
        end
        prevBusy = bus.busy;
      end
      checkOutput("done_cycle", doneAt, EXP_DONE);
    end else begin
      quietBad = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.spi_csb !== 1'b1 || bus.busy !== 1'b0) quietBad++;
      end
      checkOutput("ignored_quiet", quietBad, 0);
      checkOutput("ignored_sclk_edges", sclkEdges - edges0, 0);
    end
    bus.tdc_enable = 1'b1;
    bus.pause      = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int partial0;
    int frames0;
    int rises0;

    vecs[0] = '{en: 1'b1, pz: 1'b0, rb: 8'h40, run: 1'b1, expDone: 1'b1, expErr: 1'b0};
    vecs[1] = '{en: 1'b1, pz: 1'b0, rb: 8'h41, run: 1'b1, expDone: 1'b1, expErr: RB};
    vecs[2] = '{en: 1'b1, pz: 1'b1, rb: 8'h40, run: 1'b0, expDone: 1'b1, expErr: RB};
    vecs[3] = '{en: 1'b0, pz: 1'b0, rb: 8'h40, run: 1'b0, expDone: 1'b1, expErr: RB};
    vecs[4] = '{en: 1'b1, pz: 1'b0, rb: 8'h40, run: 1'b1, expDone: 1'b1, expErr: 1'b0};

    rst            = 1'b1;
    bus.tdc_enable = 1'b1;
    bus.soft_reset = 1'b0;
    bus.pause      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_csb", bus.spi_csb, 1'b1);
    checkOutput("rst_sclk", bus.spi_sclk, 1'b0);
    checkOutput("rst_mosi", bus.spi_mosi, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.init_done, 1'b0);
    checkOutput("rst_error", bus.init_error, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      $display("[TB] vector %0d", v);
      partial0 = partialFrames;
      applyStimulus(vecs[v].en, vecs[v].pz, vecs[v].rb, vecs[v].run, 1'b0);
      checkOutput("vec_done", bus.init_done, vecs[v].expDone);
      checkOutput("vec_error", bus.init_error, vecs[v].expErr);
      checkOutput("vec_frames_left", expQ.size(), 0);
      checkOutput("vec_partial", partialFrames - partial0, 0);
    end

    $display("[TB] abort during second frame");
    rbByte   = 8'h40;
    partial0 = partialFrames;
    expQ.push_back(16'h4140);
    pulseTrigger();
    repeat (36 * CLK_DIV + 10) @(negedge clk);
    bus.tdc_enable = 1'b0;
    @(negedge clk);
    checkOutput("abort_csb", bus.spi_csb, 1'b1);
    checkOutput("abort_sclk", bus.spi_sclk, 1'b0);
    checkOutput("abort_mosi", bus.spi_mosi, 1'b0);
    checkOutput("abort_busy", bus.busy, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("abort_done", bus.init_done, 1'b0);
    checkOutput("abort_frames_left", expQ.size(), 0);
    checkOutput("abort_partial", partialFrames - partial0, 1);
    bus.tdc_enable = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b1, 1'b0);
    checkOutput("restart_done", bus.init_done, 1'b1);
    checkOutput("restart_frames_left", expQ.size(), 0);

    $display("[TB] retrigger while busy");
    frames0 = framesSeen;
    rises0  = doneRises;
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b1, 1'b1);
    checkOutput("retrig_frames", framesSeen - frames0, NTXN);
    checkOutput("retrig_done_rises", doneRises - rises0, 1);
    checkOutput("retrig_frames_left", expQ.size(), 0);

    $display("[TB] reset mid-frame");
    partial0 = partialFrames;
    pulseTrigger();
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_csb", bus.spi_csb, 1'b1);
    checkOutput("midrst_sclk", bus.spi_sclk, 1'b0);
    checkOutput("midrst_mosi", bus.spi_mosi, 1'b0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_done", bus.init_done, 1'b0);
    checkOutput("midrst_error", bus.init_error, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_partial", partialFrames - partial0, 1);
    checkOutput("midrst_frames_left", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
